// File: rtl/motor_pwm_bridge.sv
// Multi-channel H-bridge PWM driver: shared timebase, sticky delayed standby release,
// wrap-aligned duty updates and a brake dead-time on fwd<->rev reversal.
// Optional per-period duty ramping is enabled by defining MOTOR_PWM_RAMP_EN.
module motor_pwm_bridge #(
  parameter int NCH         = 2,
  parameter int PWM_BITS    = 11,
  parameter int DUTY_BITS   = 8,
  parameter int STBY_LOG2   = 27,
  parameter int DEAD_CYCLES = 1024,
  parameter int RAMP_STEP   = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           we_i,
  input  logic [2:0]     sel_i,
  input  logic [31:0]    ctrl_i,
  output logic           stby_o,
  output logic [NCH-1:0] in1_o,
  output logic [NCH-1:0] in2_o,
  output logic [NCH-1:0] pwm_o,
  output logic [NCH-1:0] busy_o
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  // Step clamped so it always fits the DUTY_BITS+1 working width.
  localparam int RS = (RAMP_STEP > (1 << DUTY_BITS)) ? (1 << DUTY_BITS) : RAMP_STEP;
  localparam logic [DUTY_BITS:0] RSTEP = (DUTY_BITS + 1)'(RS);

  typedef enum logic {ST_RUN, ST_DEAD} state_t;

  logic [PWM_BITS-1:0]  cnt_reg;
  logic [STBY_LOG2:0]   stby_cnt_reg;
  logic                 wrap;
  logic [DUTY_BITS-1:0] cmp_val;
  logic                 unused_ok;

  assign wrap      = &cnt_reg;
  assign cmp_val   = cnt_reg[PWM_BITS-1 -: DUTY_BITS];
  assign stby_o    = stby_cnt_reg[STBY_LOG2];
  assign unused_ok = ^{ctrl_i, RSTEP};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg      <= '0;
      stby_cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      // Saturates once the top bit is set, which keeps stby_o sticky.
      if (!stby_cnt_reg[STBY_LOG2])
        stby_cnt_reg <= stby_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_t               state_reg, state_next;
      logic [1:0]           tgt_dir_reg;
      logic [DUTY_BITS-1:0] tgt_duty_reg;
      logic [1:0]           dir_reg, dir_next;
      logic [DUTY_BITS-1:0] duty_reg, duty_next, duty_wrap;
      logic [DEAD_W-1:0]    dead_reg, dead_next;
      logic                 in1_reg, in2_reg, pwm_reg;
      logic                 wr_hit, reversal;

      assign wr_hit   = we_i && (sel_i == 3'(gi));
      assign reversal = ((dir_reg == 2'b01) && (tgt_dir_reg == 2'b10)) ||
                        ((dir_reg == 2'b10) && (tgt_dir_reg == 2'b01));

`ifdef MOTOR_PWM_RAMP_EN
      always_comb begin
        duty_wrap = tgt_duty_reg;
        if (tgt_duty_reg > duty_reg) begin
          if (({1'b0, tgt_duty_reg} - {1'b0, duty_reg}) > RSTEP)
            duty_wrap = duty_reg + RSTEP[DUTY_BITS-1:0];
        end else if (duty_reg > tgt_duty_reg) begin
          if (({1'b0, duty_reg} - {1'b0, tgt_duty_reg}) > RSTEP)
            duty_wrap = duty_reg - RSTEP[DUTY_BITS-1:0];
        end
      end
`else
      assign duty_wrap = tgt_duty_reg;
`endif

      always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        duty_next  = duty_reg;
        dead_next  = dead_reg;
        case (state_reg)
          ST_RUN: begin
            if (wrap)
              duty_next = duty_wrap;
            if (reversal) begin
              state_next = ST_DEAD;
              dir_next   = 2'b11;
              duty_next  = '0;
              dead_next  = DEAD_W'(DEAD_CYCLES);
            end else if (tgt_dir_reg != dir_reg) begin
              dir_next = tgt_dir_reg;
            end
          end
          ST_DEAD: begin
            dead_next = dead_reg - 1'b1;
            // Exit applies whatever target is current; no second dead-time.
            if (dead_reg == DEAD_W'(1)) begin
              state_next = ST_RUN;
              dir_next   = tgt_dir_reg;
              duty_next  = '0;
            end
          end
          default: state_next = ST_RUN;
        endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_reg    <= ST_RUN;
          tgt_dir_reg  <= '0;
          tgt_duty_reg <= '0;
          dir_reg      <= '0;
          duty_reg     <= '0;
          dead_reg     <= '0;
          in1_reg      <= 1'b0;
          in2_reg      <= 1'b0;
          pwm_reg      <= 1'b0;
        end else begin
          state_reg <= state_next;
          dir_reg   <= dir_next;
          duty_reg  <= duty_next;
          dead_reg  <= dead_next;
          if (wr_hit) begin
            tgt_dir_reg  <= ctrl_i[17:16];
            tgt_duty_reg <= ctrl_i[DUTY_BITS-1:0];
          end
          in1_reg <= dir_reg[1];
          in2_reg <= dir_reg[0];
          pwm_reg <= (cmp_val < duty_reg);
        end
      end

      assign in1_o[gi]  = in1_reg & stby_o;
      assign in2_o[gi]  = in2_reg & stby_o;
      assign pwm_o[gi]  = pwm_reg & stby_o;
      assign busy_o[gi] = (state_reg == ST_DEAD);
    end
  endgenerate

endmodule

// File: tb/tb_motor_pwm_bridge.sv
// Self-checking bench for motor_pwm_bridge: directed scenarios plus random command traffic,
// compared each cycle against a time-based behavioural model.
module tb_motor_pwm_bridge;
  localparam int NCH = 2, PWM_BITS = 6, DUTY_BITS = 4, STBY_LOG2 = 4;
  localparam int DEAD_CYCLES = 8, RAMP_STEP = 4;
  localparam int PERIOD = 1 << PWM_BITS;
  localparam int STBY_T = 1 << STBY_LOG2;
`ifdef MOTOR_PWM_RAMP_EN
  localparam int HI_AFTER_DROP = 44;
  localparam int HI_AFTER_REV  = 16;
`else
  localparam int HI_AFTER_DROP = 16;
  localparam int HI_AFTER_REV  = 40;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           we_i = 1'b0;
  logic [2:0]     sel_i = '0;
  logic [31:0]    ctrl_i = '0;
  logic           stby_o;
  logic [NCH-1:0] in1_o, in2_o, pwm_o, busy_o;

  always #5 clk_i = ~clk_i;

  motor_pwm_bridge #(
    .NCH(NCH), .PWM_BITS(PWM_BITS), .DUTY_BITS(DUTY_BITS), .STBY_LOG2(STBY_LOG2),
    .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .sel_i(sel_i), .ctrl_i(ctrl_i),
    .stby_o(stby_o), .in1_o(in1_o), .in2_o(in2_o), .pwm_o(pwm_o), .busy_o(busy_o)
  );

  int tests = 0, fails = 0;
  int t;
  int m_tdir[NCH], m_tduty[NCH], m_dir[NCH], m_duty[NCH], m_exit[NCH];
  bit m_dead[NCH];
  int hi_acc[NCH], last_hi[NCH];
  int busy_acc1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic bit is_rev(input int a, input int b);
    return (a == 1 && b == 2) || (a == 2 && b == 1);
  endfunction

  function automatic int next_duty(input int cur, input int tgt);
`ifdef MOTOR_PWM_RAMP_EN
    if (tgt > cur) return (cur + RAMP_STEP < tgt) ? cur + RAMP_STEP : tgt;
    else return (cur - RAMP_STEP > tgt) ? cur - RAMP_STEP : tgt;
`else
    return tgt;
`endif
  endfunction

  task automatic model_reset();
    t = 0;
    busy_acc1 = 0;
    for (int c = 0; c < NCH; c++) begin
      m_tdir[c] = 0; m_tduty[c] = 0; m_dir[c] = 0; m_duty[c] = 0;
      m_exit[c] = 0; m_dead[c] = 0; hi_acc[c] = 0; last_hi[c] = 0;
    end
  endtask

  // One clock edge: predict outputs from pre-edge model state, then advance the model.
  task automatic tick();
    int e_in1, e_in2, e_pwm, e_busy, ph;
    bit st;
    @(posedge clk_i);
    #1;
    t++;
    ph = (t - 1) % PERIOD;
    st = (t >= STBY_T);
    e_in1 = 0; e_in2 = 0; e_pwm = 0; e_busy = 0;
    for (int c = 0; c < NCH; c++) begin
      if (st) begin
        e_in1 |= ((m_dir[c] >> 1) & 1) << c;
        e_in2 |= (m_dir[c] & 1) << c;
        if ((ph >> (PWM_BITS - DUTY_BITS)) < m_duty[c]) e_pwm |= 1 << c;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (m_dead[c]) begin
        if (t == m_exit[c]) begin
          m_dead[c] = 0; m_dir[c] = m_tdir[c]; m_duty[c] = 0;
        end
      end else if (is_rev(m_dir[c], m_tdir[c])) begin
        m_dead[c] = 1; m_dir[c] = 3; m_duty[c] = 0; m_exit[c] = t + DEAD_CYCLES;
      end else begin
        m_dir[c] = m_tdir[c];
        if (ph == PERIOD - 1) m_duty[c] = next_duty(m_duty[c], m_tduty[c]);
      end
      e_busy |= int'(m_dead[c]) << c;
    end
    if (we_i && sel_i < NCH) begin
      m_tdir[sel_i]  = ctrl_i[17:16];
      m_tduty[sel_i] = ctrl_i[DUTY_BITS-1:0];
    end
    check("stby", 32'(stby_o), 32'(st));
    check("in1", 32'(in1_o), 32'(e_in1));
    check("in2", 32'(in2_o), 32'(e_in2));
    check("pwm", 32'(pwm_o), 32'(e_pwm));
    check("busy", 32'(busy_o), 32'(e_busy));
    for (int c = 0; c < NCH; c++) hi_acc[c] += int'(pwm_o[c]);
    busy_acc1 += int'(busy_o[1]);
    if (t % PERIOD == 0) begin
      for (int c = 0; c < NCH; c++) begin
        last_hi[c] = hi_acc[c];
        hi_acc[c] = 0;
      end
    end
  endtask

  task automatic write(input int sel, input int dir, input int duty);
    ctrl_i = $urandom;
    ctrl_i[17:16] = dir[1:0];
    ctrl_i[DUTY_BITS-1:0] = duty[DUTY_BITS-1:0];
    sel_i = sel[2:0];
    we_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic run_periods(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      while (t % PERIOD != 0) tick();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stby", 32'(stby_o), 0);
    check("rst_outs", 32'({in1_o, in2_o, pwm_o, busy_o}), 0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Standby release and first command.
    tick();
    write(0, 1, 8);
    repeat (12) tick();
    tick();
    check("stby_pre", 32'(stby_o), 0);
    tick();
    check("stby_rise", 32'(stby_o), 1);
    check("dir_fwd", 32'({in1_o[0], in2_o[0]}), 32'b01);

    // Steady duty high-times per period.
    run_periods(5);
    check("hi_duty8", 32'(last_hi[0]), 32);
    write(0, 1, 0);
    run_periods(5);
    check("hi_duty0", 32'(last_hi[0]), 0);
    write(0, 1, 15);
    run_periods(5);
    check("hi_duty15", 32'(last_hi[0]), 60);

    // Mid-period duty change waits for the wrap.
    while (t % PERIOD != 20) tick();
    write(0, 1, 4);
    run_periods(1);
    check("hi_keep_old", 32'(last_hi[0]), 60);
    run_periods(1);
    check("hi_new", 32'(last_hi[0]), 32'(HI_AFTER_DROP));

`ifdef MOTOR_PWM_RAMP_EN
    write(0, 1, 0);
    run_periods(5);
    write(0, 1, 15);
    run_periods(1);
    run_periods(1); check("ramp_16", 32'(last_hi[0]), 16);
    run_periods(1); check("ramp_32", 32'(last_hi[0]), 32);
    run_periods(1); check("ramp_48", 32'(last_hi[0]), 48);
    run_periods(1); check("ramp_60", 32'(last_hi[0]), 60);
`endif

    // Reversal on ch1 with dead-time brake.
    write(1, 1, 10);
    run_periods(5);
    while (t % PERIOD != 44) tick();
    busy_acc1 = 0;
    write(1, 2, 10);
    tick();
    tick();
    check("dead_brake", 32'({in1_o[1], in2_o[1]}), 32'b11);
    check("dead_busy", 32'(busy_o[1]), 1);
    check("dead_pwm", 32'(pwm_o[1]), 0);
    repeat (16) tick();
    check("busy_len", 32'(busy_acc1), 32'(DEAD_CYCLES));
    check("rev_dir", 32'({in1_o[1], in2_o[1]}), 32'b10);
    run_periods(2);
    check("hi_after_rev", 32'(last_hi[1]), 32'(HI_AFTER_REV));

    // Out-of-range select is ignored.
    write(5, 2, 7);
    repeat (10) tick();
    check("sel5_busy", 32'(busy_o), 0);

    // Random command traffic.
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0)
        write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      else
        tick();
    end

    // Asynchronous reset during DEAD.
    write(1, 1, 5);
    repeat (30) tick();
    write(1, 2, 5);
    repeat (3) tick();
    check("pre_rst_busy", 32'(busy_o[1]), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_outs", 32'({in1_o, in2_o, pwm_o}), 0);
    check("async_rst_busy", 32'(busy_o), 0);
    check("async_rst_stby", 32'(stby_o), 0);
    model_reset();
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
